csa_frame_accumulator: RTL

- Streaming multi-operand accumulator wrapped around one carrySaveAdder instance.
- Each accepted beat carries two 32-bit operands. They are added to the running low accumulator word through the CSA (in1 = acc_lo, in2 = a, in3 = b).
- The CSA's 2-bit carry is folded into a high-word counter.
- Frames are delimited by first/last flags. The full-width frame total is returned over a valid/ready result port; this is the front end for multi-operand sums in the datapath.

---
 rtl/csa_frame_accumulator.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/csa_frame_accumulator.sv
// rtl/csa_frame_accumulator.sv - framed multi-operand accumulator around a carry-save adder
//
// carrySaveAdder: three W-bit unsigned operands in, W-bit sum and 2-bit carry out
//   in1, in2, in3 : operands
//   sum           : low W bits of in1 + in2 + in3
//   carry         : bits W+1..W of in1 + in2 + in3
//
// csa_frame_accumulator: accumulates two operands per accepted beat into a frame total
//   clk, rst_n                         : clock, asynchronous active-low reset
//   in_valid/in_ready                  : operand beat handshake
//   in_first/in_last                   : frame delimiters
//   in_a, in_b                         : unsigned operands
//   out_valid/out_ready                : frame result handshake
//   out_sum, out_hi, out_beats, out_ovf: frame total low/high words, beat count, high-word wrap
//   err                                : one-cycle pulse after a non-first beat in IDLE

module carrySaveAdder #(
    parameter int W = 32
) (
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    output logic [W-1:0] sum,
    output logic [1:0]   carry
);
    logic         c_in;
    logic [W-1:0] s_vec;
    logic [W-1:0] c_vec;
    logic [W+1:0] full;

    assign c_in  = 1'b0;
    assign s_vec = in1 ^ in2 ^ in3;
    assign c_vec = (in1 & in2) | (in1 & in3) | (in2 & in3);
    // Resolve the saved carries; the top two bits are the carry word.
    assign full  = {2'b00, s_vec} + {1'b0, c_vec, 1'b0} + {{(W+1){1'b0}}, c_in};
    assign sum   = full[W-1:0];
    assign carry = full[W+1:W];
endmodule

module csa_frame_accumulator #(
    parameter int HI_WIDTH  = 8,
    parameter int CNT_WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [31:0]          in_a,
    input  logic [31:0]          in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_sum,
    output logic [HI_WIDTH-1:0]  out_hi,
    output logic [CNT_WIDTH-1:0] out_beats,
    output logic                 out_ovf,
    output logic                 err
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                state_q, state_d;
    logic [31:0]           acc_lo_q, acc_lo_d;
    logic [HI_WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [CNT_WIDTH-1:0]  beats_q, beats_d;
    logic                  ovf_q, ovf_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic [31:0]           csa_in1;
    logic [31:0]           csa_sum;
    logic [1:0]            csa_carry;
    logic [HI_WIDTH-1:0]   hi_base;
    logic [HI_WIDTH:0]     hi_ext;
    logic [CNT_WIDTH-1:0]  beats_inc;

    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;

    // A first beat starts from zero regardless of what is left in the registers.
    assign csa_in1   = in_first ? 32'd0 : acc_lo_q;
    assign hi_base   = in_first ? '0 : acc_hi_q;
    assign hi_ext    = {1'b0, hi_base} + {{(HI_WIDTH-1){1'b0}}, csa_carry};
    assign beats_inc = (&beats_q) ? beats_q : beats_q + 1'b1;

    carrySaveAdder #(.W(32)) u_csa (
        .in1   (csa_in1),
        .in2   (in_a),
        .in3   (in_b),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

    always_comb begin
        state_d  = state_q;
        acc_lo_d = acc_lo_q;
        acc_hi_d = acc_hi_q;
        beats_d  = beats_q;
        ovf_d    = ovf_q;
        err_d    = 1'b0;

        if (accept) begin
            if (state_q == IDLE && !in_first) begin
                // Stray continuation beat: drop it, flag it, keep state.
                err_d = 1'b1;
            end else begin
                acc_lo_d = csa_sum;
                acc_hi_d = hi_ext[HI_WIDTH-1:0];
                ovf_d    = (in_first ? 1'b0 : ovf_q) | hi_ext[HI_WIDTH];
                beats_d  = in_first ? CNT_WIDTH'(1) : beats_inc;
                state_d  = in_last ? DONE : ACCUM;
            end
        end

        if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_lo_q <= '0;
            acc_hi_q <= '0;
            beats_q  <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_lo_q <= acc_lo_d;
            acc_hi_q <= acc_hi_d;
            beats_q  <= beats_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign out_sum   = acc_lo_q;
    assign out_hi    = acc_hi_q;
    assign out_beats = beats_q;
    assign out_ovf   = ovf_q;
    assign err       = err_q;
endmodule
